// File: rtl/qif_spike_monitor.sv
// -----------------------------------------------------------------------------
// qif_spike_monitor
//
// Watches the QIF neuron spike level, turns each rising edge into a spike event,
// measures the inter-spike interval (ISI) in enabled clock cycles and queues the
// intervals in a small first-word-fall-through FIFO read through a valid/ready
// port. In parallel it counts spikes over a fixed window of enabled cycles and
// publishes the per-window rate.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   ena         enable; when low the timer, window, spike counter and edge
//               detector all hold
//   spike_in    spike level from the neuron (one or more cycles per spike)
//   isi_data    ISI at the FIFO head (don't-care while isi_valid is low)
//   isi_valid   FIFO not empty
//   isi_ready   consumer takes the head entry this cycle
//   rate_count  spikes in the last completed window, saturating at 255
//   rate_valid  one-cycle pulse when rate_count updates
//   overflow    sticky: an ISI was dropped because the FIFO was full
//   clr_ovf     synchronous clear of overflow (a simultaneous drop wins)
//
// Parameters
//   TS_W     ISI timer / FIFO data width, timer saturates at all-ones
//   DEPTH    FIFO entries, power of two, >= 2
//   WIN_LEN  rate window length in enabled cycles, >= 2
// -----------------------------------------------------------------------------
//  state  | meaning
//  -------+-------------------------------------------------------------
//  S_IDLE | no spike since reset; first edge only starts the ISI timer
//  S_RUN  | at least one spike seen; every edge pushes the running ISI
// -----------------------------------------------------------------------------
module qif_spike_monitor #(
   parameter int TS_W    = 16,
   parameter int DEPTH   = 4,
   parameter int WIN_LEN = 256
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            spike_in,
   output logic [TS_W-1:0] isi_data,
   output logic            isi_valid,
   input  logic            isi_ready,
   output logic [7:0]      rate_count,
   output logic            rate_valid,
   output logic            overflow,
   input  logic            clr_ovf
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;

   localparam logic [WCW-1:0]  WIN_LAST  = WCW'(WIN_LEN - 1);
   localparam logic [AW:0]     CNT_FULL  = (AW + 1)'(DEPTH);
   localparam logic [TS_W-1:0] TIMER_MAX = '1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   logic            prev;
   logic            spk_edge;
   logic            push;
   logic            timer_run;
   logic [TS_W-1:0] timer;

   logic [TS_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            fifo_full;
   logic            pop;
   logic            wr_en;
   logic            drop;

   logic [WCW-1:0]  win_cnt;
   logic [7:0]      spk_cnt;
   logic [8:0]      spk_sum;
   logic [7:0]      spk_sat;

   // ---------------------------------------------------------------- edge detect
   // prev only follows spike_in on enabled cycles, so a pulse that straddles a
   // disabled stretch is still seen as a single spike.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= 1'b0;
      end else if (ena) begin
         prev <= spike_in;
      end
   end

   assign spk_edge = ena & spike_in & ~prev;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (spk_edge) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      push      = 1'b0;
      timer_run = 1'b0;
      case (state_q)
         S_RUN: begin
            push      = spk_edge;
            timer_run = 1'b1;
         end
         default: begin
            push      = 1'b0;
            timer_run = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------- ISI timer
   // Reloaded with 1 on every edge so that the value seen at the next edge is
   // exactly the number of enabled cycles between the two edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= '0;
      end else if (spk_edge) begin
         timer <= TS_W'(1);
      end else if (ena && timer_run && (timer != TIMER_MAX)) begin
         timer <= timer + TS_W'(1);
      end
   end

   // ---------------------------------------------------------------- FIFO
   assign fifo_full = (count == CNT_FULL);
   assign isi_valid = (count != '0);
   assign isi_data  = mem[rd_ptr];
   assign pop       = isi_valid & isi_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign wr_en     = push & (~fifo_full | pop);
   assign drop      = push & fifo_full & ~pop;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= timer;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- rate window
   // The edge on the wrap cycle belongs to the window that is closing.
   assign spk_sum = {1'b0, spk_cnt} + 9'(spk_edge);
   assign spk_sat = spk_sum[8] ? 8'hFF : spk_sum[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt    <= '0;
         spk_cnt    <= '0;
         rate_count <= '0;
         rate_valid <= 1'b0;
      end else begin
         rate_valid <= 1'b0;
         if (ena) begin
            if (win_cnt == WIN_LAST) begin
               rate_count <= spk_sat;
               rate_valid <= 1'b1;
               spk_cnt    <= '0;
               win_cnt    <= '0;
            end else begin
               spk_cnt    <= spk_sat;
               win_cnt    <= win_cnt + WCW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_qif_spike_monitor.sv
module tb_qif_spike_monitor;

   localparam int TS_W    = 16;
   localparam int DEPTH   = 4;
   localparam int WIN_LEN = 16;

   logic            clk;
   logic            rst_n;
   logic            ena;
   logic            spike_in;
   logic [TS_W-1:0] isi_data;
   logic            isi_valid;
   logic            isi_ready;
   logic [7:0]      rate_count;
   logic            rate_valid;
   logic            overflow;
   logic            clr_ovf;

   qif_spike_monitor #(
      .TS_W    (TS_W),
      .DEPTH   (DEPTH),
      .WIN_LEN (WIN_LEN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .spike_in   (spike_in),
      .isi_data   (isi_data),
      .isi_valid  (isi_valid),
      .isi_ready  (isi_ready),
      .rate_count (rate_count),
      .rate_valid (rate_valid),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: spikes are timestamped with the index of the enabled
   // cycle they occur on; an ISI is the difference of two timestamps.
   bit m_prev;
   bit m_seen;
   int m_idx;
   int m_last;
   int q[$];
   int m_wspk;
   int m_rate;
   bit m_rv;
   bit m_ovf;

   function automatic void model_reset();
      m_prev = 0;
      m_seen = 0;
      m_idx  = 0;
      m_last = 0;
      q.delete();
      m_wspk = 0;
      m_rate = 0;
      m_rv   = 0;
      m_ovf  = 0;
   endfunction

   function automatic void model_step(bit e, bit s, bit r, bit c);
      bit e_det;
      bit pop;
      bit drop;
      int isi;
      drop  = 0;
      pop   = (q.size() > 0) && r;
      e_det = e && s && !m_prev;
      m_rv  = 0;
      if (pop) void'(q.pop_front());
      if (e_det) begin
         if (m_seen) begin
            isi = m_idx - m_last;
            if (isi > 65535) isi = 65535;
            if (q.size() < DEPTH) q.push_back(isi);
            else drop = 1;
         end
         m_seen = 1;
         m_last = m_idx;
      end
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
      if (e) begin
         if (e_det) m_wspk++;
         if ((m_idx % WIN_LEN) == WIN_LEN - 1) begin
            m_rate = (m_wspk > 255) ? 255 : m_wspk;
            m_rv   = 1;
            m_wspk = 0;
         end
         m_prev = s;
         m_idx++;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      check("m_isi_valid", 32'(isi_valid), 32'(q.size() > 0));
      if (q.size() > 0) check("m_isi_data", 32'(isi_data), q[0]);
      check("m_rate_count", 32'(rate_count), m_rate);
      check("m_rate_valid", 32'(rate_valid), 32'(m_rv));
      check("m_overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic tick(input bit e, input bit s, input bit r, input bit c);
      ena       = e;
      spike_in  = s;
      isi_ready = r;
      clr_ovf   = c;
      @(posedge clk);
      model_step(e, s, r, c);
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      ena       = 1'b0;
      spike_in  = 1'b0;
      isi_ready = 1'b0;
      clr_ovf   = 1'b0;
      #2;
      check("rst_isi_valid", 32'(isi_valid), 0);
      check("rst_rate_count", 32'(rate_count), 0);
      check("rst_rate_valid", 32'(rate_valid), 0);
      check("rst_overflow", 32'(overflow), 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      int s0;
      int len0;
      int s1;
      int len1;
      int exp_isi;
   } isi_vec_t;

   isi_vec_t tbl[6];
   int       exp3[4];

   initial begin
      bit s;
      bit e;
      bit r;
      rst_n     = 1'b0;
      ena       = 1'b0;
      spike_in  = 1'b0;
      isi_ready = 1'b0;
      clr_ovf   = 1'b0;
      model_reset();

      tbl[0] = '{s0: 10, len0: 1, s1: 15,  len1: 1, exp_isi: 5};
      tbl[1] = '{s0: 20, len0: 3, s1: 30,  len1: 1, exp_isi: 10};
      tbl[2] = '{s0: 0,  len0: 1, s1: 2,   len1: 1, exp_isi: 2};
      tbl[3] = '{s0: 5,  len0: 4, s1: 10,  len1: 2, exp_isi: 5};
      tbl[4] = '{s0: 3,  len0: 1, s1: 200, len1: 1, exp_isi: 197};
      tbl[5] = '{s0: 1,  len0: 2, s1: 4,   len1: 5, exp_isi: 3};
      exp3   = '{4, 4, 4, 3};

      #1;
      do_reset();

      // Table: two spikes, consumer stalled, expect exactly one ISI.
      for (int i = 0; i < 6; i++) begin
         do_reset();
         for (int c = 0; c <= tbl[i].s1 + tbl[i].len1 + 1; c++) begin
            s = ((c >= tbl[i].s0) && (c < tbl[i].s0 + tbl[i].len0)) ||
                ((c >= tbl[i].s1) && (c < tbl[i].s1 + tbl[i].len1));
            tick(1, s, 0, 0);
         end
         check("tbl_valid", 32'(isi_valid), 1);
         check("tbl_data", 32'(isi_data), tbl[i].exp_isi);
         tick(1, 0, 1, 0);
         check("tbl_drained", 32'(isi_valid), 0);
      end

      // Spikes at 10, 15, 40 with the consumer always ready.
      do_reset();
      for (int c = 0; c <= 45; c++) begin
         tick(1, (c == 10) || (c == 15) || (c == 40), 1, 0);
         if (c == 10) check("seq1_first_no_entry", 32'(isi_valid), 0);
         if (c == 15) begin
            check("seq1_valid15", 32'(isi_valid), 1);
            check("seq1_isi5", 32'(isi_data), 5);
         end
         if (c == 16) check("seq1_popped", 32'(isi_valid), 0);
         if (c == 40) check("seq1_isi25", 32'(isi_data), 25);
      end
      check("seq1_ovf", 32'(overflow), 0);

      // Overflow: 6 spikes, 4 apart, nobody reading.
      do_reset();
      for (int c = 0; c <= 22; c++) begin
         tick(1, (c % 4 == 0) && (c <= 20), 0, 0);
         if (c == 16) check("seq2_ovf_before", 32'(overflow), 0);
         if (c == 20) check("seq2_ovf_set", 32'(overflow), 1);
      end
      tick(1, 0, 0, 1);
      check("seq2_ovf_clr", 32'(overflow), 0);
      for (int k = 0; k < 4; k++) begin
         check("seq2_valid", 32'(isi_valid), 1);
         check("seq2_data", 32'(isi_data), 4);
         tick(1, 0, 1, 0);
      end
      check("seq2_empty", 32'(isi_valid), 0);

      // Full FIFO, edge coincides with a pop.
      do_reset();
      for (int c = 0; c <= 19; c++) begin
         tick(1, ((c % 4 == 0) && (c <= 16)) || (c == 19), c == 19, 0);
      end
      check("seq3_ovf", 32'(overflow), 0);
      for (int k = 0; k < 4; k++) begin
         check("seq3_valid", 32'(isi_valid), 1);
         check("seq3_data", 32'(isi_data), exp3[k]);
         tick(1, 0, 1, 0);
      end
      check("seq3_empty", 32'(isi_valid), 0);

      // Rate window of 16 with a spike on the wrap cycle.
      do_reset();
      for (int c = 0; c <= 32; c++) begin
         tick(1, (c == 2) || (c == 8) || (c == 15), 1, 0);
         check("seq4_rate_valid", 32'(rate_valid), 32'((c == 15) || (c == 31)));
         if (c == 15) check("seq4_rate3", 32'(rate_count), 3);
         if (c == 20) check("seq4_rate_hold", 32'(rate_count), 3);
         if (c == 31) check("seq4_rate0", 32'(rate_count), 0);
      end

      // Enable low for 7 cycles between spikes 12 wall cycles apart.
      do_reset();
      for (int c = 0; c <= 13; c++) begin
         e = !((c >= 3) && (c <= 9));
         tick(e, (c == 0) || (c == 12), 0, 0);
      end
      check("seq5_valid", 32'(isi_valid), 1);
      check("seq5_isi5", 32'(isi_data), 5);

      // Reset with two entries queued, then confirm the FSM restarted in IDLE.
      do_reset();
      for (int c = 0; c <= 8; c++) tick(1, (c == 0) || (c == 3) || (c == 7), 0, 0);
      check("seq6_two_entries", 32'(isi_valid), 1);
      do_reset();
      for (int c = 0; c <= 6; c++) begin
         tick(1, (c == 2) || (c == 6), 0, 0);
         if (c == 5) check("seq6_idle_first_edge", 32'(isi_valid), 0);
      end
      check("seq6_valid", 32'(isi_valid), 1);
      check("seq6_isi4", 32'(isi_data), 4);

      // Randomized traffic against the model.
      do_reset();
      s = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            do_reset();
            s = 0;
         end
         if ($urandom_range(0, 3) == 0) s = !s;
         e = ($urandom_range(0, 9) != 0);
         r = ($urandom_range(0, 2) == 0);
         tick(e, s, r, $urandom_range(0, 15) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
